stage_decode: RTL and testbench

Instruction decode stage of the pipelined RV32I core. It consumes the IF-ID register and the instruction word from the instruction RAM, reads the register file, and generates immediates and control fields. It resolves jumps and branches in ID and drives the fetch-stage redirect, stall and squash inputs. It detects load-use and branch-operand hazards and produces the ID-EX pipeline register.

---
 rtl/stage_decode_pkg.sv | 107 ++++++++++
 rtl/stage_decode_reg_file.sv | 36 +++
 rtl/stage_decode.sv | 241 ++++++++++++++++++++++++
 tb/tb_stage_decode.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_decode_pkg.sv
// Shared types, RV32I encodings and immediate helpers for the decode stage.
package stage_decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] { SRC_A_RS1, SRC_A_PC, SRC_A_ZERO } alu_src_a_t;
    typedef enum logic       { SRC_B_RS2, SRC_B_IMM } alu_src_b_t;
    typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_PC4 } wb_sel_t;
    typedef enum logic [1:0] { MEM_B, MEM_H, MEM_W } mem_size_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus_four;
    } if_id_reg_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] pc;
        logic [31:0] pc_plus_four;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        alu_op_t     alu_op;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        logic        mem_rd;
        logic        mem_wr;
        mem_size_t   mem_size;
        logic        mem_unsigned;
        logic        reg_write;
        wb_sel_t     wb_sel;
    } id_ex_reg_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

    // alt selects SUB/SRA; callers decide when funct7 bit 5 is meaningful
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SRL:  return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/stage_decode_reg_file.sv
// 32x32 register file: two combinational reads, one write, WB write-through, x0 reads 0.
module stage_decode_reg_file (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == 5'd0)
            rdata1 = '0;
        else if (we && waddr == raddr1)
            rdata1 = wdata;
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == 5'd0)
            rdata2 = '0;
        else if (we && waddr == raddr2)
            rdata2 = wdata;
    end

endmodule

// File: rtl/stage_decode.sv
// RV32I decode stage: regfile read, immediates, control, ID-resolved jumps/branches,
// hazard detection and the ID-EX pipeline register.
module stage_decode
    import stage_decode_pkg::*;
#(
    parameter logic [31:0] RESET_NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        stall_i,
    input  if_id_reg_t  if_id_reg_i,
    input  logic [31:0] imem_rdata_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_write_i,
    input  logic        ex_is_load_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_reg_write_i,
    input  logic        mem_is_load_i,
    input  logic [31:0] mem_result_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_data_i,
    output logic        stall_o,
    output logic        squash_o,
    output logic        instr_jal_o,
    output logic        instr_jalr_o,
    output logic        branch_taken_o,
    output logic [31:0] jal_addr_o,
    output logic [31:0] branch_addr_o,
    output logic [31:0] jalr_addr_o,
    output id_ex_reg_t  id_ex_reg_o
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;

    assign instr  = if_id_reg_i.valid ? imem_rdata_i : RESET_NOP_INSTR;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    logic [31:0] rf_rdata1, rf_rdata2;

    stage_decode_reg_file u_reg_file (
        .clk    (clk),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (wb_we_i),
        .waddr  (wb_rd_i),
        .wdata  (wb_data_i)
    );

    id_ex_reg_t dec;
    logic       legal, use_rs1, use_rs2, is_branch, is_jal, is_jalr;

    always_comb begin
        dec              = '0;
        legal            = 1'b1;
        use_rs1          = 1'b0;
        use_rs2          = 1'b0;
        is_branch        = 1'b0;
        is_jal           = 1'b0;
        is_jalr          = 1'b0;
        dec.valid        = if_id_reg_i.valid;
        dec.pc           = if_id_reg_i.pc;
        dec.pc_plus_four = if_id_reg_i.pc_plus_four;
        dec.rs1_addr     = rs1;
        dec.rs2_addr     = rs2;
        dec.rd_addr      = rd;
        dec.rs1_data     = rf_rdata1;
        dec.rs2_data     = rf_rdata2;
        dec.alu_op       = ALU_ADD;
        dec.alu_src_a    = SRC_A_RS1;
        dec.alu_src_b    = SRC_B_RS2;
        dec.mem_size     = MEM_W;
        dec.wb_sel       = WB_ALU;

        case (opcode)
            OPC_LUI: begin
                dec.imm       = imm_u(instr);
                dec.alu_src_a = SRC_A_ZERO;
                dec.alu_src_b = SRC_B_IMM;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm       = imm_u(instr);
                dec.alu_src_a = SRC_A_PC;
                dec.alu_src_b = SRC_B_IMM;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                is_jal        = 1'b1;
                dec.imm       = imm_j(instr);
                dec.reg_write = 1'b1;
                dec.wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                legal         = (f3 == 3'd0);
                is_jalr       = 1'b1;
                use_rs1       = 1'b1;
                dec.imm       = imm_i(instr);
                dec.reg_write = 1'b1;
                dec.wb_sel    = WB_PC4;
            end
            OPC_BRANCH: begin
                legal         = (f3 != 3'd2) && (f3 != 3'd3);
                is_branch     = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.imm       = imm_b(instr);
                dec.alu_op    = ALU_SUB;
            end
            OPC_LOAD: begin
                legal            = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                use_rs1          = 1'b1;
                dec.imm          = imm_i(instr);
                dec.alu_src_b    = SRC_B_IMM;
                dec.mem_rd       = 1'b1;
                dec.mem_size     = mem_size_t'(f3[1:0]);
                dec.mem_unsigned = f3[2];
                dec.reg_write    = 1'b1;
                dec.wb_sel       = WB_MEM;
            end
            OPC_STORE: begin
                legal         = (f3[2] == 1'b0) && (f3[1:0] != 2'd3);
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.imm       = imm_s(instr);
                dec.alu_src_b = SRC_B_IMM;
                dec.mem_wr    = 1'b1;
                dec.mem_size  = mem_size_t'(f3[1:0]);
            end
            OPC_OP_IMM: begin
                // shift-immediates reuse the funct7 slot as a sub-opcode
                if (f3 == F3_SLL)
                    legal = (f7 == F7_BASE);
                else if (f3 == F3_SRL)
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                use_rs1       = 1'b1;
                dec.imm       = imm_i(instr);
                dec.alu_src_b = SRC_B_IMM;
                dec.alu_op    = alu_from_f3(f3, (f3 == F3_SRL) && f7[5]);
                dec.reg_write = 1'b1;
            end
            OPC_OP: begin
                legal         = (f7 == F7_BASE) ||
                                ((f7 == F7_ALT) && (f3 == F3_ADD || f3 == F3_SRL));
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.alu_op    = alu_from_f3(f3, f7[5]);
                dec.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
            dec.mem_rd    = 1'b0;
            dec.mem_wr    = 1'b0;
            use_rs1       = 1'b0;
            use_rs2       = 1'b0;
            is_branch     = 1'b0;
            is_jal        = 1'b0;
            is_jalr       = 1'b0;
        end
    end

    // Operands for branch compare and jalr; MEM ALU result beats WB write-through.
    logic        fwd1, fwd2;
    logic [31:0] op1, op2;

    assign fwd1 = mem_reg_write_i && !mem_is_load_i && mem_rd_i == rs1 && rs1 != 5'd0;
    assign fwd2 = mem_reg_write_i && !mem_is_load_i && mem_rd_i == rs2 && rs2 != 5'd0;
    assign op1  = fwd1 ? mem_result_i : rf_rdata1;
    assign op2  = fwd2 ? mem_result_i : rf_rdata2;

    logic cond;

    always_comb begin
        case (f3)
            F3_BEQ:  cond = (op1 == op2);
            F3_BNE:  cond = (op1 != op2);
            F3_BLT:  cond = ($signed(op1) <  $signed(op2));
            F3_BGE:  cond = ($signed(op1) >= $signed(op2));
            F3_BLTU: cond = (op1 <  op2);
            F3_BGEU: cond = (op1 >= op2);
            default: cond = 1'b0;
        endcase
    end

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, ctrl, hazard;

    assign ex_hit1  = use_rs1 && rs1 != 5'd0 && ex_reg_write_i && ex_rd_i == rs1;
    assign ex_hit2  = use_rs2 && rs2 != 5'd0 && ex_reg_write_i && ex_rd_i == rs2;
    assign mem_hit1 = use_rs1 && rs1 != 5'd0 && mem_reg_write_i && mem_rd_i == rs1;
    assign mem_hit2 = use_rs2 && rs2 != 5'd0 && mem_reg_write_i && mem_rd_i == rs2;
    assign ctrl     = is_branch || is_jalr;

    // ALU results in EX/MEM are forwarded in EX, so only loads and ID-resolved control stall.
    assign hazard = if_id_reg_i.valid &&
                    ((ex_is_load_i && (ex_hit1 || ex_hit2)) ||
                     (ctrl && (ex_hit1 || ex_hit2)) ||
                     (ctrl && mem_is_load_i && (mem_hit1 || mem_hit2)));

    logic go;

    assign go             = if_id_reg_i.valid && !hazard && !stall_i;
    assign instr_jal_o    = go && is_jal;
    assign instr_jalr_o   = go && is_jalr;
    assign branch_taken_o = go && is_branch && cond;
    assign squash_o       = instr_jal_o || instr_jalr_o || branch_taken_o;
    assign stall_o        = stall_i || hazard;

    assign jal_addr_o    = if_id_reg_i.pc + imm_j(instr);
    assign branch_addr_o = if_id_reg_i.pc + imm_b(instr);
    assign jalr_addr_o   = (op1 + imm_i(instr)) & ~32'd1;

    always_ff @(posedge clk) begin
        if (rst_i)
            id_ex_reg_o <= '0;
        else if (stall_i)
            id_ex_reg_o <= id_ex_reg_o;
        else if (hazard)
            id_ex_reg_o <= '0;
        else
            id_ex_reg_o <= dec;
    end

    a_one_redirect: assert property (@(posedge clk) disable iff (rst_i)
        $onehot0({instr_jal_o, instr_jalr_o, branch_taken_o}));

endmodule

// File: tb/tb_stage_decode.sv
// Self-checking bench for stage_decode: directed scenarios plus a randomized ISA-level model.
module tb_stage_decode;
    import stage_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, stall_i;
    if_id_reg_t  if_id;
    logic [31:0] imem;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_rw, ex_ld, mem_rw, mem_ld, wb_we;
    logic [31:0] mem_res, wb_data;
    logic        stall_o, squash_o, jal_o, jalr_o, br_o;
    logic [31:0] jal_addr, br_addr, jalr_addr;
    id_ex_reg_t  idex;

    int errors = 0;
    int checks = 0;
    logic [31:0] mregs [32];

    always #5 clk = ~clk;

    stage_decode dut (
        .clk(clk), .rst_i(rst_i), .stall_i(stall_i), .if_id_reg_i(if_id), .imem_rdata_i(imem),
        .ex_rd_i(ex_rd), .ex_reg_write_i(ex_rw), .ex_is_load_i(ex_ld),
        .mem_rd_i(mem_rd), .mem_reg_write_i(mem_rw), .mem_is_load_i(mem_ld), .mem_result_i(mem_res),
        .wb_rd_i(wb_rd), .wb_we_i(wb_we), .wb_data_i(wb_data),
        .stall_o(stall_o), .squash_o(squash_o), .instr_jal_o(jal_o), .instr_jalr_o(jalr_o),
        .branch_taken_o(br_o), .jal_addr_o(jal_addr), .branch_addr_o(br_addr), .jalr_addr_o(jalr_addr),
        .id_ex_reg_o(idex)
    );

    // ISA encoders
    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic br_model(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            default: return a >= b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(logic v, logic [31:0] pc, logic [31:0] ir);
        if_id.valid = v;
        if_id.pc = pc;
        if_id.pc_plus_four = pc + 32'd4;
        imem = ir;
    endtask

    task automatic clr_side();
        stall_i = 0; ex_rd = 0; ex_rw = 0; ex_ld = 0;
        mem_rd = 0; mem_rw = 0; mem_ld = 0; mem_res = 0;
        wb_rd = 0; wb_we = 0; wb_data = 0;
    endtask

    task automatic wb_write(logic [4:0] r, logic [31:0] d);
        set_id(0, 0, 32'h0);
        wb_we = 1; wb_rd = r; wb_data = d;
        tick();
        wb_we = 0;
        if (r != 0) mregs[r] = d;
    endtask

    task automatic test_reset();
        rst_i = 1; clr_side(); set_id(0, 0, 32'h0);
        tick(); tick();
        checks++; if (idex.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", idex.valid); end
        checks++; if (idex !== '0) begin errors++; $display("FAIL reset_idex got %h exp 0", idex); end
        checks++; if (stall_o !== 1'b0 || squash_o !== 1'b0) begin errors++; $display("FAIL reset_ctl got %b%b exp 00", stall_o, squash_o); end
        rst_i = 0;
    endtask

    task automatic test_addi();
        set_id(1, 32'h10, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011));
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL addi_stall got %b exp 0", stall_o); end
        tick();
        checks++;
        if (idex.valid !== 1'b1 || idex.rd_addr !== 5'd1 || idex.imm !== 32'd5 ||
            idex.reg_write !== 1'b1 || idex.pc !== 32'h10 || idex.illegal !== 1'b0) begin
            errors++; $display("FAIL addi_idex got v=%b rd=%0d imm=%h rw=%b pc=%h exp 1 1 5 1 10",
                               idex.valid, idex.rd_addr, idex.imm, idex.reg_write, idex.pc);
        end
    endtask

    task automatic test_load_use();
        ex_ld = 1; ex_rw = 1; ex_rd = 2;
        set_id(1, 32'h20, enc_r(7'd0, 5'd1, 5'd2, 3'd0, 5'd3));
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %b exp 1", stall_o); end
        tick();
        checks++; if (idex.valid !== 1'b0 || idex.reg_write !== 1'b0) begin errors++; $display("FAIL loaduse_bubble got v=%b rw=%b exp 0 0", idex.valid, idex.reg_write); end
        ex_ld = 0; ex_rw = 0; ex_rd = 0;
        mem_ld = 1; mem_rw = 1; mem_rd = 2;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL loaduse_release got %b exp 0", stall_o); end
        tick();
        checks++; if (idex.valid !== 1'b1 || idex.rd_addr !== 5'd3) begin errors++; $display("FAIL loaduse_issue got v=%b rd=%0d exp 1 3", idex.valid, idex.rd_addr); end
        clr_side();
    endtask

    task automatic test_branch();
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        set_id(1, 32'h40, enc_b(13'd16, 5'd2, 5'd1, 3'd0));
        #1;
        checks++; if (br_o !== 1'b1 || squash_o !== 1'b1) begin errors++; $display("FAIL beq_taken got br=%b sq=%b exp 1 1", br_o, squash_o); end
        checks++; if (br_addr !== 32'h50) begin errors++; $display("FAIL beq_addr got %h exp 00000050", br_addr); end
        // EX ALU producer of a branch operand must stall, not redirect
        ex_rw = 1; ex_rd = 1;
        #1;
        checks++; if (stall_o !== 1'b1 || br_o !== 1'b0 || squash_o !== 1'b0) begin errors++; $display("FAIL beq_exdep got st=%b br=%b sq=%b exp 1 0 0", stall_o, br_o, squash_o); end
        clr_side();
        wb_write(5'd2, 32'd8);
        set_id(1, 32'h40, enc_b(13'd16, 5'd2, 5'd1, 3'd0));
        #1;
        checks++; if (br_o !== 1'b0 || squash_o !== 1'b0) begin errors++; $display("FAIL beq_nottaken got br=%b sq=%b exp 0 0", br_o, squash_o); end
        // invalid entry: no redirect, no hazard, bubble enters ID-EX
        if_id.valid = 0; ex_rw = 1; ex_ld = 1; ex_rd = 1;
        #1;
        checks++; if (squash_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL invalid_ctl got sq=%b st=%b exp 0 0", squash_o, stall_o); end
        tick();
        checks++; if (idex.valid !== 1'b0) begin errors++; $display("FAIL invalid_idex got %b exp 0", idex.valid); end
        clr_side();
    endtask

    task automatic test_jalr();
        wb_write(5'd5, 32'h0);
        mem_rw = 1; mem_rd = 5; mem_res = 32'h1003;
        wb_we = 1; wb_rd = 5; wb_data = 32'h5000;
        set_id(1, 32'h80, enc_i(12'd8, 5'd5, 3'd0, 5'd1, 7'b1100111));
        #1;
        checks++; if (jalr_o !== 1'b1 || squash_o !== 1'b1) begin errors++; $display("FAIL jalr_redirect got j=%b sq=%b exp 1 1", jalr_o, squash_o); end
        checks++; if (jalr_addr !== 32'h100A) begin errors++; $display("FAIL jalr_addr got %h exp 0000100a", jalr_addr); end
        wb_we = 0;
        tick();
        mregs[5] = 32'h5000;
        checks++; if (idex.reg_write !== 1'b1 || idex.wb_sel !== WB_PC4 || idex.rd_addr !== 5'd1) begin errors++; $display("FAIL jalr_link got rw=%b sel=%0d rd=%0d exp 1 2 1", idex.reg_write, idex.wb_sel, idex.rd_addr); end
        mem_ld = 1;
        #1;
        checks++; if (stall_o !== 1'b1 || jalr_o !== 1'b0 || squash_o !== 1'b0) begin errors++; $display("FAIL jalr_memload got st=%b j=%b sq=%b exp 1 0 0", stall_o, jalr_o, squash_o); end
        clr_side();
        // JAL with address wrap
        set_id(1, 32'hFFFF_FFF0, enc_j(21'h20, 5'd1));
        #1;
        checks++; if (jal_o !== 1'b1 || jal_addr !== 32'h10) begin errors++; $display("FAIL jal_wrap got j=%b a=%h exp 1 00000010", jal_o, jal_addr); end
        tick();
    endtask

    task automatic test_x0_and_wb();
        ex_ld = 1; ex_rw = 1; ex_rd = 0;
        set_id(1, 32'h100, enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd4));
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL x0_nohazard got %b exp 0", stall_o); end
        tick();
        clr_side();
        wb_we = 1; wb_rd = 6; wb_data = 32'hDEAD;
        set_id(1, 32'h104, enc_i(12'd0, 5'd6, 3'd0, 5'd7, 7'b0010011));
        tick();
        wb_we = 0; mregs[6] = 32'hDEAD;
        checks++; if (idex.rs1_data !== 32'hDEAD) begin errors++; $display("FAIL wb_through got %h exp 0000dead", idex.rs1_data); end
    endtask

    task automatic test_illegal_stall();
        set_id(1, 32'h200, 32'h0000_0073);
        #1;
        checks++; if (squash_o !== 1'b0) begin errors++; $display("FAIL ecall_redirect got %b exp 0", squash_o); end
        tick();
        checks++; if (idex.illegal !== 1'b1 || idex.reg_write !== 1'b0 || idex.valid !== 1'b1) begin errors++; $display("FAIL ecall_idex got il=%b rw=%b v=%b exp 1 0 1", idex.illegal, idex.reg_write, idex.valid); end
        set_id(1, 32'h204, enc_i(12'h55, 5'd0, 3'd0, 5'd9, 7'b0010011));
        tick();
        stall_i = 1;
        set_id(1, 32'h208, enc_j(21'h40, 5'd1));
        #1;
        checks++; if (stall_o !== 1'b1 || squash_o !== 1'b0) begin errors++; $display("FAIL stall_ctl got st=%b sq=%b exp 1 0", stall_o, squash_o); end
        tick();
        checks++; if (idex.rd_addr !== 5'd9 || idex.pc !== 32'h204) begin errors++; $display("FAIL stall_hold got rd=%0d pc=%h exp 9 00000204", idex.rd_addr, idex.pc); end
        rst_i = 1; ex_ld = 1; ex_rw = 1; ex_rd = 1;
        set_id(1, 32'h20C, enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
        tick();
        checks++; if (idex.valid !== 1'b0) begin errors++; $display("FAIL reset_midstall got %b exp 0", idex.valid); end
        rst_i = 0; clr_side();
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        pool[0] = 32'd5; pool[1] = 32'd5; pool[2] = 32'h8000_0000;
        pool[3] = 32'h7FFF_FFFF; pool[4] = 32'hFFFF_FFFF; pool[5] = $urandom;
        for (int r = 1; r < 8; r++) wb_write(5'(r), pool[$urandom_range(0, 5)]);
        for (int it = 0; it < 60; it++) begin
            int kind;
            logic [4:0]  ra, rb, rd;
            logic [31:0] pc, ir, exp_imm;
            logic [2:0]  f3;
            logic [11:0] i12;
            logic [12:0] b13;
            logic [20:0] j21;
            logic        exp_sq, exp_rw;
            kind = $urandom_range(0, 4);
            ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(1, 31));
            pc = {$urandom} & 32'hFFFF_FFFC;
            exp_sq = 0; exp_rw = 1; exp_imm = 0;
            case (kind)
                0: begin
                    i12 = 12'($urandom);
                    ir = enc_i(i12, ra, 3'd0, rd, 7'b0010011);
                    exp_imm = 32'($signed(i12));
                end
                1: ir = enc_r(7'd0, rb, ra, 3'd0, rd);
                2: ir = enc_r(7'h20, rb, ra, 3'd0, rd);
                3: begin
                    case ($urandom_range(0, 5))
                        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4;
                        3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
                    endcase
                    b13 = {12'($urandom), 1'b0};
                    ir = enc_b(b13, rb, ra, f3);
                    exp_imm = 32'($signed(b13));
                    exp_sq = br_model(f3, ra == 0 ? 32'd0 : mregs[ra], rb == 0 ? 32'd0 : mregs[rb]);
                    exp_rw = 0;
                    rd = ir[11:7];
                end
                default: begin
                    j21 = {20'($urandom), 1'b0};
                    ir = enc_j(j21, rd);
                    exp_imm = 32'($signed(j21));
                    exp_sq = 1;
                    ra = ir[19:15];
                end
            endcase
            set_id(1, pc, ir);
            #1;
            checks++; if (squash_o !== exp_sq) begin errors++; $display("FAIL rnd%0d_squash kind=%0d got %b exp %b", it, kind, squash_o, exp_sq); end
            if (kind == 3) begin
                checks++; if (br_addr !== pc + exp_imm) begin errors++; $display("FAIL rnd%0d_braddr got %h exp %h", it, br_addr, pc + exp_imm); end
            end
            if (kind == 4) begin
                checks++; if (jal_addr !== pc + exp_imm) begin errors++; $display("FAIL rnd%0d_jaladdr got %h exp %h", it, jal_addr, pc + exp_imm); end
            end
            tick();
            checks++;
            if (idex.valid !== 1'b1 || idex.rd_addr !== rd || idex.reg_write !== exp_rw ||
                idex.imm !== exp_imm || idex.rs1_data !== (ra == 0 ? 32'd0 : mregs[ra])) begin
                errors++; $display("FAIL rnd%0d_idex kind=%0d got v=%b rd=%0d rw=%b imm=%h rs1=%h exp rd=%0d rw=%b imm=%h rs1=%h",
                                   it, kind, idex.valid, idex.rd_addr, idex.reg_write, idex.imm, idex.rs1_data,
                                   rd, exp_rw, exp_imm, ra == 0 ? 32'd0 : mregs[ra]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_jalr();
        test_x0_and_wb();
        test_illegal_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
